// File: rtl/systolic_feeder.sv
// Skewed row/column feeder for an NxN systolic MAC array, with local A/B matrix stores.
// Optional one-cycle accumulator clear phase before streaming: define FEEDER_CLEAR_EN.
module systolic_feeder #(
    parameter int N = 3,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           wr_en,
    input  logic           wr_sel,
    input  logic [3:0]     wr_addr,
    input  logic [W-1:0]   wr_data,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [N*W-1:0] a_out,
    output logic [N*W-1:0] b_out,
    output logic           mac_en,
    output logic           mac_clr
);

    localparam int NN    = N * N;
    localparam int AW    = $clog2(NN);
    localparam int TW    = $clog2(3 * N - 1);
    localparam int TLAST = 3 * N - 3;
    localparam logic [4:0] NN5 = 5'(NN);

    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] t, t_nxt;
    logic [W-1:0]  a_mem [NN];
    logic [W-1:0]  b_mem [NN];
    logic [W-1:0]  a_nxt [NN];
    logic [W-1:0]  b_nxt [NN];
    logic          wr_ok;

    logic           busy_d, done_d, mac_en_d, mac_clr_d;
    logic [N*W-1:0] a_d, b_d;

    assign wr_ok = wr_en && !busy && ({1'b0, wr_addr} < NN5);

    // Feeds are computed from the post-write store so a write coinciding with start is used.
    always_comb begin
        a_nxt = a_mem;
        b_nxt = b_mem;
        if (wr_ok) begin
            if (wr_sel) b_nxt[wr_addr[AW-1:0]] = wr_data;
            else        a_nxt[wr_addr[AW-1:0]] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            t       <= '0;
            a_mem   <= '{default: '0};
            b_mem   <= '{default: '0};
            busy    <= 1'b0;
            done    <= 1'b0;
            mac_en  <= 1'b0;
            mac_clr <= 1'b0;
            a_out   <= '0;
            b_out   <= '0;
        end else begin
            state   <= state_nxt;
            t       <= t_nxt;
            a_mem   <= a_nxt;
            b_mem   <= b_nxt;
            busy    <= busy_d;
            done    <= done_d;
            mac_en  <= mac_en_d;
            mac_clr <= mac_clr_d;
            a_out   <= a_d;
            b_out   <= b_d;
        end
    end

    always_comb begin
        state_nxt = state;
        t_nxt     = t;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef FEEDER_CLEAR_EN
                    state_nxt = CLEAR;
`else
                    state_nxt = STREAM;
`endif
                    t_nxt = '0;
                end
            end
            CLEAR: begin
                state_nxt = STREAM;
                t_nxt     = '0;
            end
            STREAM: begin
                if (t == TW'(TLAST)) begin
                    state_nxt = DONE;
                    t_nxt     = '0;
                end else begin
                    t_nxt = t + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that they can be registered without lag.
    always_comb begin
        int unsigned tn;
        int unsigned k;
        busy_d   = (state_nxt != IDLE);
        done_d   = (state_nxt == DONE);
        mac_en_d = (state_nxt == STREAM);
`ifdef FEEDER_CLEAR_EN
        mac_clr_d = (state_nxt == CLEAR);
`else
        mac_clr_d = 1'b0;
`endif
        a_d = '0;
        b_d = '0;
        tn  = 32'(t_nxt);
        k   = 0;
        if (state_nxt == STREAM) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (tn >= i && tn < i + N) begin
                    k = tn - i;
                    a_d[i*W +: W] = a_nxt[AW'(i * N + k)];
                    b_d[i*W +: W] = b_nxt[AW'(k * N + i)];
                end
            end
        end
    end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter: N, default 3, array dimension (legal 2..4); matrices are NxN.
REQ-002 Parameter: W, default 8, element width, two's complement.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: reset  in  1  asynchronous active-low reset.
REQ-006 Port: wr_en  in  1  matrix-store write strobe.
REQ-007 Port: wr_sel  in  1  0 = matrix A, 1 = matrix B.
REQ-008 Port: wr_addr  in  4  element index, row*N+col.
REQ-009 Port: wr_data  in  W  element value.
REQ-010 Port: start  in  1  begin one stream pass.
REQ-011 Port: busy  out  1  pass in progress.
REQ-012 Port: done  out  1  one-cycle pass-complete pulse.
REQ-013 Port: a_out  out  N*W  row feeds; slice i drives west edge of array row i.
REQ-014 Port: b_out  out  N*W  column feeds; slice j drives north edge of array column j.
REQ-015 Port: mac_en  out  1  accumulate enable to every MAC cell.
REQ-016 Port: mac_clr  out  1  synchronous active-high clear to every MAC cell.

Function
REQ-017 The block SHALL hold A and B in internal NxN registers, written at the rising edge when wr_en=1 and busy=0.
REQ-018 Writes with wr_addr >= N*N SHALL be ignored; writes while busy=1 SHALL be ignored.
REQ-019 FSM states SHALL be IDLE, CLEAR, STREAM, DONE.
REQ-020 IDLE: start=1 at an edge SHALL move to CLEAR (or directly to STREAM when CLEAR is compiled out, REQ-031); start while not IDLE SHALL be ignored.
REQ-021 start and wr_en in the same IDLE cycle: the write SHALL commit and the pass SHALL use the new value.
REQ-022 CLEAR SHALL last one cycle with mac_clr=1, mac_en=0, feeds zero.
REQ-023 STREAM SHALL last exactly 3N-2 cycles, indexed t = 0..3N-3, with mac_en=1 throughout.
REQ-024 During STREAM, a_out slice i SHALL equal A[i][t-i] when 0 <= t-i < N, else 0.
REQ-025 During STREAM, b_out slice j SHALL equal B[t-j][j] when 0 <= t-j < N, else 0.
REQ-026 After t = 3N-3 the FSM SHALL enter DONE for one cycle (done=1, mac_en=0, feeds zero) and then return to IDLE.
REQ-027 busy SHALL be 1 in CLEAR, STREAM and DONE, and 0 in IDLE.
REQ-028 Outside STREAM, a_out, b_out and mac_en SHALL be 0; all outputs SHALL be registered.

Reset
REQ-029 reset=0 SHALL immediately force state IDLE, all outputs 0, the stream counter 0 and both matrix stores 0, including mid-pass; no done pulse is emitted for an aborted pass.
REQ-030 After reset deasserts, the first start SHALL be honoured on the first rising edge.

Configuration
REQ-031 Macro FEEDER_CLEAR_EN: when defined, CLEAR exists and start-to-first-feed latency is 2 cycles; when undefined, IDLE goes directly to STREAM, mac_clr is tied to 0, and the latency is 1 cycle.

Verification
REQ-032 N=3, FEEDER_CLEAR_EN defined, A=identity, B=1..9 row-major, start pulse -> mac_clr high for 1 cycle, mac_en high for 7 cycles, done at cycle 9 after start, array out_c = B.
REQ-033 A=all 2, B=all -3 -> every out_c = -18 (8'hEE); a_out slice 2 is zero at t=0,1 and 2 at t=2..4.
REQ-034 start asserted again during STREAM -> ignored; exactly one done pulse; a wr_en during busy does not change the stored matrix.
REQ-035 reset pulled low at STREAM t=3 -> outputs 0 asynchronously, no done pulse; a reload plus start completes a full correct pass.
REQ-036 FEEDER_CLEAR_EN undefined -> mac_clr stays 0, first nonzero a_out slice 0 appears 1 cycle after the start edge, done 8 cycles after start.
